// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified-memory arbiter.
//   state_t  : arbiter FSM states
//   PORT_*   : port identifiers (grant encoding, also drives mem_iord)
//   LAT_MAX  : largest supported read latency; CNT_W sizes the down-counter
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   typedef logic port_t;
   localparam port_t PORT_IF = 1'b0;
   localparam port_t PORT_D  = 1'b1;

   localparam int LAT_MAX = 4;
   localparam int CNT_W   = $clog2(LAT_MAX);
   typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational port picker for the memory arbiter.
//   i_if_req : fetch request pending
//   i_d_req  : data request pending
//   i_last   : port granted last (only consulted with MEM_ARB_RR_EN)
//   o_grant  : port to serve (PORT_IF / PORT_D)
// Build option MEM_ARB_RR_EN: ties alternate against i_last; otherwise the
// data port always wins a tie.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic  i_if_req,
   input  logic  i_d_req,
   input  port_t i_last,
   output port_t o_grant
);

`ifdef MEM_ARB_RR_EN
   always_comb begin
      o_grant = PORT_D;
      if (i_if_req && i_d_req)
         o_grant = (i_last == PORT_D) ? PORT_IF : PORT_D;
      else if (i_if_req)
         o_grant = PORT_IF;
   end
`else
   // Fixed priority: last-grant history is irrelevant.
   logic w_unused_last;
   assign w_unused_last = i_last;

   always_comb begin
      o_grant = PORT_D;
      if (i_if_req && !i_d_req)
         o_grant = PORT_IF;
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: sequences fetch and data requests onto the shared word memory.
//   clk, rst            : clock, synchronous active-high reset
//   if_req/if_addr      : fetch request in; if_ack/if_err/if_rdata out
//   d_req/d_we/d_addr/d_wdata : data request in; d_ack/d_err/d_rdata out
//   mem_*               : memory control, address, write data, read data
//   busy                : FSM not idle
// Build option MEM_ARB_RR_EN: round-robin tie break with a last-grant register.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MEM_DEPTH = 21,
   parameter int LAT       = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic              if_err,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic              d_err,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_iord,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   state_t            r_state, w_next;
   port_t             r_port, r_iord, w_pick, w_last;
   logic              r_err, r_we;
   cnt_t              r_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata, r_if_rdata, r_d_rdata;

   logic              w_any, w_oor;
   logic [ADDR_W-1:0] w_req_addr;

   assign w_any      = if_req | d_req;
   assign w_req_addr = (w_pick == PORT_D) ? d_addr : if_addr;
   assign w_oor      = (w_req_addr >= ADDR_W'(MEM_DEPTH));

   mem_arb_pick u_pick (
      .i_if_req (if_req),
      .i_d_req  (d_req),
      .i_last   (w_last),
      .o_grant  (w_pick)
   );

`ifdef MEM_ARB_RR_EN
   // Reset to data so the first tie after reset goes to fetch.
   port_t r_last;
   always_ff @(posedge clk) begin
      if (rst)
         r_last <= PORT_D;
      else if (r_state == IDLE && w_any)
         r_last <= w_pick;
   end
   assign w_last = r_last;
`else
   assign w_last = PORT_D;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic; stores take one ACCESS cycle regardless of LAT
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_any) w_next = w_oor ? RESP : ACCESS;
         ACCESS:  if (r_we || r_cnt == '0) w_next = RESP;
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Outputs: only strobes/acks are decoded, memory-side values come from
   // registers that change only when an access is actually launched.
   always_comb begin
      mem_read  = (r_state == ACCESS) && !r_we;
      mem_write = (r_state == ACCESS) &&  r_we;
      if_ack    = (r_state == RESP) && (r_port == PORT_IF);
      d_ack     = (r_state == RESP) && (r_port == PORT_D);
      if_err    = if_ack && r_err;
      d_err     = d_ack  && r_err;
      busy      = (r_state != IDLE);
   end

   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign mem_iord  = r_iord;
   assign if_rdata  = r_if_rdata;
   assign d_rdata   = r_d_rdata;

   // Transaction registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_port     <= PORT_IF;
         r_err      <= 1'b0;
         r_we       <= 1'b0;
         r_cnt      <= '0;
         r_iord     <= PORT_IF;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_if_rdata <= '0;
         r_d_rdata  <= '0;
      end else begin
         if (r_state == IDLE && w_any) begin
            r_port <= w_pick;
            r_err  <= w_oor;
            // Out-of-range requests leave the memory-side registers alone.
            if (!w_oor) begin
               r_addr <= w_req_addr;
               r_iord <= w_pick;
               r_we   <= (w_pick == PORT_D) && d_we;
               r_cnt  <= cnt_t'(LAT - 1);
               if (w_pick == PORT_D) r_wdata <= d_wdata;
            end
         end else if (r_state == ACCESS && !r_we) begin
            if (r_cnt == '0) begin
               if (r_iord == PORT_D) r_d_rdata  <= mem_rdata;
               else                  r_if_rdata <= mem_rdata;
            end else begin
               r_cnt <= r_cnt - 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;

   logic        if_ack_v[2], if_err_v[2], d_ack_v[2], d_err_v[2];
   logic        iord_v[2], rd_v[2], wr_v[2], busy_v[2];
   logic [31:0] if_rdata_v[2], d_rdata_v[2], maddr_v[2], mwdata_v[2], mrdata_v[2];

   int ntests = 0, nfail = 0;
   int cyc = 0;
   int sel = 0;          // which DUT (0: LAT=1, 1: LAT=3) is under test
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(int i);
      return (i == 5) ? 32'h8C22_0004 : 32'h1000_0000 + i;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int L = (g == 0) ? 1 : 3;
      logic [31:0] mem [0:31];
      int rc = 0;
      initial for (int i = 0; i < 32; i++) mem[i] = init_word(i);
      // Read data is only presented in the last read cycle; garbage otherwise.
      always @(posedge clk) begin
         rc <= rd_v[g] ? rc + 1 : 0;
         if (wr_v[g]) mem[maddr_v[g][4:0]] <= mwdata_v[g];
      end
      assign mrdata_v[g] = (rd_v[g] && rc == L - 1) ? mem[maddr_v[g][4:0]] : 32'hBAD0_0000;

      mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(21), .LAT(L)) u_dut (
         .clk(clk), .rst(rst),
         .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack_v[g]), .if_err(if_err_v[g]),
         .if_rdata(if_rdata_v[g]),
         .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
         .d_ack(d_ack_v[g]), .d_err(d_err_v[g]), .d_rdata(d_rdata_v[g]),
         .mem_iord(iord_v[g]), .mem_read(rd_v[g]), .mem_write(wr_v[g]),
         .mem_addr(maddr_v[g]), .mem_wdata(mwdata_v[g]), .mem_rdata(mrdata_v[g]),
         .busy(busy_v[g])
      );
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   // ---------------- transaction-level model ----------------
   // A granted transaction is described by its grant cycle and the cycle its
   // ack is due; every expected output is derived from those timestamps.
   logic [31:0] ref_mem [0:31];
   initial for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);

   bit          m_act = 0, m_err = 0, m_we = 0, m_port = 0, m_last = 1;
   int          m_tack = 0;
   logic [31:0] m_addr = '0;
   logic [31:0] e_ifr = '0, e_dr = '0, e_addr = '0, e_wd = '0;
   bit          e_iord = 0;

   always @(posedge clk) begin : mdl
      int n, lat;
      bit p;
      logic [31:0] a;
      n   = cyc;
      lat = (sel == 0) ? 1 : 3;
      if (rst) begin
         m_act = 0; e_ifr = '0; e_dr = '0; e_addr = '0; e_wd = '0; e_iord = 0; m_last = 1;
      end else begin
         if (m_act && !m_err && !m_we && n == m_tack - 1) begin
            if (m_port) e_dr = ref_mem[m_addr[4:0]];
            else        e_ifr = ref_mem[m_addr[4:0]];
         end
         if (m_act && n == m_tack) m_act = 0;
         else if (!m_act && (if_req || d_req)) begin
            if (if_req && d_req) begin
`ifdef MEM_ARB_RR_EN
               p = (m_last == 1) ? 1'b0 : 1'b1;
`else
               p = 1'b1;
`endif
            end else p = d_req;
            a      = p ? d_addr : if_addr;
            m_port = p;
            m_we   = p && d_we;
            m_err  = (a >= 21);
            m_addr = a;
            m_tack = n + (m_err ? 1 : (m_we ? 2 : lat + 1));
            if (!m_err) begin
               e_addr = a; e_iord = p;
               if (m_we) begin e_wd = d_wdata; ref_mem[a[4:0]] = d_wdata; end
            end
            m_last = p;
            m_act  = 1;
         end
      end
      cyc = n + 1;
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin : cmp
      bit ack, rd, wr;
      if (chk_en) begin
         ack = m_act && (cyc == m_tack);
         rd  = m_act && !m_err && !m_we && (cyc < m_tack);
         wr  = m_act && !m_err &&  m_we && (cyc < m_tack);
         chk("if_ack",   {31'd0, if_ack_v[sel]}, {31'd0, ack && !m_port});
         chk("d_ack",    {31'd0, d_ack_v[sel]},  {31'd0, ack &&  m_port});
         chk("if_err",   {31'd0, if_err_v[sel]}, {31'd0, ack && !m_port && m_err});
         chk("d_err",    {31'd0, d_err_v[sel]},  {31'd0, ack &&  m_port && m_err});
         chk("mem_read", {31'd0, rd_v[sel]},     {31'd0, rd});
         chk("mem_write",{31'd0, wr_v[sel]},     {31'd0, wr});
         chk("busy",     {31'd0, busy_v[sel]},   {31'd0, m_act});
         chk("mem_iord", {31'd0, iord_v[sel]},   {31'd0, e_iord});
         chk("mem_addr", maddr_v[sel],    e_addr);
         chk("if_rdata", if_rdata_v[sel], e_ifr);
         chk("d_rdata",  d_rdata_v[sel],  e_dr);
         if (wr) chk("mem_wdata", mwdata_v[sel], e_wd);
      end
   end

   // ---------------- stimulus ----------------
   task automatic do_reset();
      @(negedge clk); #1 rst = 1'b1; if_req = 0; d_req = 0;
      @(negedge clk);
      chk("rst_outs", {if_ack_v[sel], d_ack_v[sel], if_err_v[sel], d_err_v[sel],
                       rd_v[sel], wr_v[sel], iord_v[sel], busy_v[sel]}, 32'd0);
      chk("rst_rdata", if_rdata_v[sel] | d_rdata_v[sel] | maddr_v[sel] | mwdata_v[sel], 32'd0);
      @(negedge clk); #1 rst = 1'b0;
   endtask

   // Issue one request, hold it until ack, return cycles from sample to ack.
   task automatic do_req(input bit p, input bit we, input logic [31:0] a,
                         input logic [31:0] wd, input int chg_at, output int dur);
      int t0;
      @(negedge clk); #1;
      if (p) begin d_req = 1; d_we = we; d_addr = a; d_wdata = wd; end
      else begin if_req = 1; if_addr = a; end
      t0  = cyc;
      dur = -1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (p ? d_ack_v[sel] : if_ack_v[sel]) begin dur = cyc - t0; break; end
         if (k == chg_at) begin #1 d_addr = 32'd9; d_wdata = 32'hFFFF_FFFF; end
      end
      #1 if_req = 0; d_req = 0;
      if (dur < 0) chk("ack_timeout", 32'd0, 32'd1);
   endtask

   initial begin : stim
      int dur, nack;
      int ord[4];
      do_reset();
      chk_en = 1'b1;

      // ---- LAT = 1 ----
      do_req(0, 0, 32'd5, '0, 0, dur);
      chk("fetch_lat", dur, 2);
      chk("fetch_data", if_rdata_v[0], 32'h8C22_0004);

      do_req(1, 1, 32'd3, 32'hDEAD_BEEF, 0, dur);
      chk("store_lat", dur, 2);
      chk("store_mem", g_dut[0].mem[3], 32'hDEAD_BEEF);

      do_req(1, 0, 32'd3, '0, 0, dur);
      chk("load_data", d_rdata_v[0], 32'hDEAD_BEEF);

      do_req(1, 0, 32'd21, '0, 0, dur);
      chk("err_lat", dur, 1);
      chk("err_rdata_kept", d_rdata_v[0], 32'hDEAD_BEEF);
      chk("err_addr_kept", maddr_v[0], 32'd3);

      do_req(0, 0, 32'd100, '0, 0, dur);
      chk("ferr_lat", dur, 1);
      chk("ferr_rdata_kept", if_rdata_v[0], 32'h8C22_0004);

      // Both ports held for four acks.
      do_reset();
      @(negedge clk); #1 if_req = 1; if_addr = 32'd7; d_req = 1; d_we = 0; d_addr = 32'd8;
      nack = 0;
      for (int k = 0; k < 40 && nack < 4; k++) begin
         @(negedge clk);
         if (d_ack_v[0])  begin ord[nack] = 1; nack++; end
         if (if_ack_v[0]) begin ord[nack] = 0; nack++; end
      end
      #1 if_req = 0; d_req = 0;
      chk("tie_count", nack, 4);
`ifdef MEM_ARB_RR_EN
      chk("tie0", ord[0], 0); chk("tie1", ord[1], 1); chk("tie2", ord[2], 0); chk("tie3", ord[3], 1);
`else
      chk("tie0", ord[0], 1); chk("tie1", ord[1], 1); chk("tie2", ord[2], 1); chk("tie3", ord[3], 1);
`endif

      // ---- LAT = 3 ----
      chk_en = 1'b0;
      sel    = 1;
      do_reset();
      chk_en = 1'b1;

      do_req(1, 0, 32'd4, '0, 1, dur);
      chk("l3_lat", dur, 4);
      chk("l3_data", d_rdata_v[1], 32'h1000_0004);

      // Reset in cycle 2 of a load.
      @(negedge clk); #1 d_req = 1; d_we = 0; d_addr = 32'd6;
      @(negedge clk);
      @(negedge clk); #1 rst = 1'b1; d_req = 0;
      @(negedge clk);
      chk("rst_mid_read", {31'd0, rd_v[1]}, 32'd0);
      chk("rst_mid_busy", {31'd0, busy_v[1]}, 32'd0);
      chk("rst_mid_rdata", d_rdata_v[1], 32'd0);
      #1 rst = 1'b0;
      nack = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (d_ack_v[1]) nack++;
      end
      chk("rst_mid_noack", nack, 0);

      do_req(0, 0, 32'd5, '0, 0, dur);
      chk("l3_fetch_lat", dur, 4);
      chk("l3_fetch_data", if_rdata_v[1], 32'h8C22_0004);

      do_req(1, 1, 32'd10, 32'h1234_5678, 0, dur);
      chk("l3_store_lat", dur, 2);
      chk("l3_store_mem", g_dut[1].mem[10], 32'h1234_5678);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
